// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants for the add/sub datapath
//
// Purpose: rounding-mode encoding, exponent limits and GRS bit positions
//          shared by the control unit and the rounding stage.
// Ports:   none (package)

package fp_pkg;

  localparam int FP_DATA_WIDTH = 32;
  localparam int FP_MENT_WIDTH = 23;
  localparam int FP_EXPO_WIDTH = 8;

  // Encoding matches the rounding_mode_in pins.
  typedef enum logic [1:0] {
    RM_RNE = 2'b00,  // nearest, ties to even
    RM_RTZ = 2'b01,  // toward zero
    RM_RUP = 2'b10,  // toward +inf
    RM_RDN = 2'b11   // toward -inf
  } round_mode_t;

  localparam logic [FP_EXPO_WIDTH-1:0] EXP_ALL_ONES   = 8'hFF;
  localparam logic [FP_EXPO_WIDTH-1:0] MAX_FINITE_EXP = 8'hFE;

  // Bit positions inside the {guard, round, sticky} vector.
  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

endpackage

// File: rtl/rounding_increment_decider.sv
// rtl/rounding_increment_decider.sv - combinational round-up and inexact decision
//
// Purpose: decides whether the stored fraction must be incremented by one ULP
//          for the selected rounding mode, and whether the result is inexact.
// Ports:
//   sign          in   result sign
//   frac_lsb      in   LSB of the fraction (tie-break for RNE)
//   grs           in   {guard, round, sticky}
//   rounding_mode in   round_mode_t encoding
//   special       in   operand is inf/NaN/zero and must pass through untouched
//   inc           out  add one ULP to the fraction
//   inexact       out  discarded bits were nonzero

module rounding_increment_decider
  import fp_pkg::*;
(
  input  logic       sign,
  input  logic       frac_lsb,
  input  logic [2:0] grs,
  input  logic [1:0] rounding_mode,
  input  logic       special,
  output logic       inc,
  output logic       inexact
);

  logic any_grs;

  always_comb begin
    any_grs = |grs;
    inc     = 1'b0;
    case (round_mode_t'(rounding_mode))
      RM_RNE:  inc = grs[GRS_G] & (grs[GRS_R] | grs[GRS_S] | frac_lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & any_grs;
      RM_RDN:  inc = sign & any_grs;
      default: inc = 1'b0;
    endcase
    // Inf/NaN/zero carry no meaningful rounding bits.
    if (special) begin
      inc = 1'b0;
    end
    inexact = any_grs & ~special;
  end

endmodule

// File: rtl/addition_stage5_rounding.sv
// rtl/addition_stage5_rounding.sv - FP add/sub rounding stage, 2-deep valid/ready pipe
//
// Purpose: applies the selected rounding mode to the normalized result,
//          re-normalizes on mantissa carry and saturates on exponent overflow.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   valid_in / ready_out      upstream handshake
//   sign_in, exponent_in,
//   mentissa_in, grs_in       normalized operand plus rounding bits
//   rounding_mode_in          sampled together with the data
//   valid_out / ready_in      downstream handshake
//   floating_out              {sign, exponent, fraction}
//   overflow_out, inexact_out status flags, qualified by valid_out

module addition_stage5_rounding
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = FP_DATA_WIDTH,
  parameter int MENT_WIDTH = FP_MENT_WIDTH,
  parameter int EXPO_WIDTH = FP_EXPO_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  sign_in,
  input  logic [EXPO_WIDTH-1:0] exponent_in,
  input  logic [MENT_WIDTH-1:0] mentissa_in,
  input  logic [2:0]            grs_in,
  input  logic [1:0]            rounding_mode_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] floating_out,
  output logic                  overflow_out,
  output logic                  inexact_out
);

  localparam logic [EXPO_WIDTH-1:0] EXP_ONES = {EXPO_WIDTH{1'b1}};
  localparam logic [EXPO_WIDTH-1:0] EXP_MAXF = {{(EXPO_WIDTH-1){1'b1}}, 1'b0};

  // Pipeline control
  logic s1_valid, s2_valid;
  logic s1_en, s2_en;

  assign s2_en     = ~s2_valid | ready_in;
  assign s1_en     = ~s1_valid | s2_en;
  assign ready_out = s1_en;

  // Stage-1 decision
  logic in_special;
  logic in_inc;
  logic in_inexact;

  assign in_special = (exponent_in == EXP_ONES) ||
                      ((exponent_in == '0) && (mentissa_in == '0));

  rounding_increment_decider u_decider (
    .sign          (sign_in),
    .frac_lsb      (mentissa_in[0]),
    .grs           (grs_in),
    .rounding_mode (rounding_mode_in),
    .special       (in_special),
    .inc           (in_inc),
    .inexact       (in_inexact)
  );

  // Stage-1 registers
  logic                  s1_sign;
  logic [EXPO_WIDTH-1:0] s1_exp;
  logic [MENT_WIDTH-1:0] s1_frac;
  logic                  s1_inc;
  logic                  s1_inexact;
  logic                  s1_special;
  logic [1:0]            s1_mode;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_frac    <= '0;
      s1_inc     <= 1'b0;
      s1_inexact <= 1'b0;
      s1_special <= 1'b0;
      s1_mode    <= 2'b00;
    end else if (s1_en) begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_sign    <= sign_in;
        s1_exp     <= exponent_in;
        s1_frac    <= mentissa_in;
        s1_inc     <= in_inc;
        s1_inexact <= in_inexact;
        s1_special <= in_special;
        s1_mode    <= rounding_mode_in;
      end
    end
  end

  // Stage-2 increment, carry re-normalization and overflow saturation
  logic [MENT_WIDTH:0]   sum;
  logic                  carry;
  logic [MENT_WIDTH-1:0] frac_r;
  logic [EXPO_WIDTH-1:0] exp_r;
  logic                  ovf;
  logic                  to_inf;
  logic [DATA_WIDTH-1:0] word_r;

  always_comb begin
    sum    = {1'b0, s1_frac} + {{MENT_WIDTH{1'b0}}, s1_inc};
    carry  = sum[MENT_WIDTH];
    // On carry the significand became 10.000..., so shift right by one:
    // fraction clears and the exponent absorbs the carry.
    frac_r = carry ? {MENT_WIDTH{1'b0}} : sum[MENT_WIDTH-1:0];
    exp_r  = s1_exp + {{(EXPO_WIDTH-1){1'b0}}, carry};
    // An all-ones exponent on a finite input can only come from the carry.
    ovf    = ~s1_special && (exp_r == EXP_ONES);

    to_inf = 1'b0;
    case (round_mode_t'(s1_mode))
      RM_RNE:  to_inf = 1'b1;
      RM_RTZ:  to_inf = 1'b0;
      RM_RUP:  to_inf = ~s1_sign;
      RM_RDN:  to_inf = s1_sign;
      default: to_inf = 1'b0;
    endcase

    word_r = {s1_sign, exp_r, frac_r};
    if (ovf) begin
      if (to_inf) begin
        word_r = {s1_sign, EXP_ONES, {MENT_WIDTH{1'b0}}};
      end else begin
        word_r = {s1_sign, EXP_MAXF, {MENT_WIDTH{1'b1}}};
      end
    end
  end

  // Stage-2 (output) registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s2_valid     <= 1'b0;
      floating_out <= '0;
      overflow_out <= 1'b0;
      inexact_out  <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        floating_out <= word_r;
        overflow_out <= ovf;
        inexact_out  <= s1_inexact | ovf;
      end
    end
  end

  assign valid_out = s2_valid;

endmodule

// File: tb/tb_addition_stage5_rounding.sv
// tb/tb_addition_stage5_rounding.sv - scoreboard bench for the rounding stage

module tb_addition_stage5_rounding;
  import fp_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        sign_in = 1'b0;
  logic [7:0]  exponent_in = '0;
  logic [22:0] mentissa_in = '0;
  logic [2:0]  grs_in = '0;
  logic [1:0]  rounding_mode_in = '0;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [31:0] floating_out;
  logic        overflow_out;
  logic        inexact_out;

  addition_stage5_rounding dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .sign_in          (sign_in),
    .exponent_in      (exponent_in),
    .mentissa_in      (mentissa_in),
    .grs_in           (grs_in),
    .rounding_mode_in (rounding_mode_in),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .floating_out     (floating_out),
    .overflow_out     (overflow_out),
    .inexact_out      (inexact_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  // Scoreboard entry: {overflow, inexact, word}
  logic [33:0] sb_q[$];
  logic [33:0] mon_exp;
  logic        rnd_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: round on the concatenated {exp, frac} so a fraction carry
  // ripples into the exponent by plain integer addition.
  function automatic logic [33:0] model(input logic s, input logic [7:0] e,
                                        input logic [22:0] f, input logic [2:0] g,
                                        input logic [1:0] m);
    logic        up;
    logic        any;
    logic [30:0] mag;
    logic        inf_dir;
    if (e == 8'hFF || (e == 8'h00 && f == 23'h0))
      return {1'b0, 1'b0, s, e, f};
    any = |g;
    case (m)
      2'b00:   up = g[2] & (g[1] | g[0] | f[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = ~s & any;
      default: up = s & any;
    endcase
    mag = {e, f} + 31'(up);
    if (mag[30:23] == 8'hFF) begin
      inf_dir = (m == 2'b00) || (m == 2'b10 && !s) || (m == 2'b11 && s);
      return {1'b1, 1'b1, s, inf_dir ? {8'hFF, 23'h0} : {8'hFE, 23'h7FFFFF}};
    end
    return {1'b0, any, s, mag};
  endfunction

  // Output monitor: pops one expectation per completed output transfer.
  always @(negedge clk_in) begin
    if (!rst_in && valid_out && ready_in) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 64'(valid_out), 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("floating_out", 64'(floating_out), 64'(mon_exp[31:0]));
        chk("overflow_out", 64'(overflow_out), 64'(mon_exp[33]));
        chk("inexact_out",  64'(inexact_out),  64'(mon_exp[32]));
      end
    end
  end

  task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] f,
                       input logic [2:0] g, input logic [1:0] m);
    sign_in = s; exponent_in = e; mentissa_in = f; grs_in = g; rounding_mode_in = m;
  endtask

  // Offer one input, wait (bounded) for acceptance, then push its expectation.
  task automatic send(input logic s, input logic [7:0] e, input logic [22:0] f,
                      input logic [2:0] g, input logic [1:0] m, input logic [33:0] x);
    int n;
    drive(s, e, f, g, m);
    valid_in = 1'b1;
    n = 0;
    forever begin
      @(negedge clk_in);
      if (ready_out) break;
      n++;
      if (n > 100) begin
        chk("send_ready_timeout", 64'(ready_out), 64'd1);
        break;
      end
    end
    @(posedge clk_in);
    sb_q.push_back(x);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 300) begin
      @(posedge clk_in);
      n++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk_in); #1;
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [2:0]  g;
    logic [1:0]  m;
    logic [33:0] x;
  } vec_t;

  vec_t dir_v[12];

  initial begin
    dir_v[0]  = '{1'b0, 8'h7F, 23'h000000, 3'b100, 2'b00, {2'b01, 32'h3F800000}};
    dir_v[1]  = '{1'b0, 8'h80, 23'h7FFFFF, 3'b110, 2'b00, {2'b01, 32'h40800000}};
    dir_v[2]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 2'b00, {2'b11, 32'h7F800000}};
    dir_v[3]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 2'b01, {2'b01, 32'h7F7FFFFF}};
    dir_v[4]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 2'b11, {2'b01, 32'h7F7FFFFF}};
    dir_v[5]  = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b100, 2'b11, {2'b11, 32'hFF800000}};
    dir_v[6]  = '{1'b0, 8'h7F, 23'h000000, 3'b001, 2'b10, {2'b01, 32'h3F800001}};
    dir_v[7]  = '{1'b1, 8'h7F, 23'h000000, 3'b001, 2'b10, {2'b01, 32'hBF800000}};
    dir_v[8]  = '{1'b0, 8'hFF, 23'h400000, 3'b111, 2'b00, {2'b00, 32'h7FC00000}};
    dir_v[9]  = '{1'b1, 8'h00, 23'h000000, 3'b111, 2'b11, {2'b00, 32'h80000000}};
    dir_v[10] = '{1'b0, 8'h00, 23'h000001, 3'b110, 2'b00, {2'b01, 32'h00000002}};
    dir_v[11] = '{1'b0, 8'h00, 23'h7FFFFF, 3'b100, 2'b00, {2'b01, 32'h00800000}};
  end

  logic [31:0] held;
  logic [33:0] xa, xb, xc;

  initial begin
    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_floating",  64'(floating_out), 64'd0);
    chk("rst_overflow",  64'(overflow_out), 64'd0);
    chk("rst_inexact",   64'(inexact_out), 64'd0);
    chk("rst_ready_out", 64'(ready_out), 64'd1);
    rst_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk_in); #1;

    // RNE tie with odd LSB, plus latency
    send(1'b0, 8'h7F, 23'h000001, 3'b100, 2'b00, {2'b01, 32'h3F800002});
    @(negedge clk_in);
    chk("lat_cycle1_valid", 64'(valid_out), 64'd0);
    @(negedge clk_in);
    chk("lat_cycle2_valid", 64'(valid_out), 64'd1);
    @(posedge clk_in); #1;

    // Directed table, back to back
    for (int i = 0; i < 12; i++)
      send(dir_v[i].s, dir_v[i].e, dir_v[i].f, dir_v[i].g, dir_v[i].m, dir_v[i].x);
    drain();

    // Back-pressure: two accepted, third refused, output held
    ready_in = 1'b0;
    xa = model(1'b0, 8'h81, 23'h123457, 3'b100, 2'b00);
    xb = model(1'b1, 8'h82, 23'h000010, 3'b011, 2'b11);
    xc = model(1'b0, 8'h83, 23'h7FFFFF, 3'b001, 2'b10);
    drive(1'b0, 8'h81, 23'h123457, 3'b100, 2'b00);
    valid_in = 1'b1;
    @(negedge clk_in);
    chk("bp_ready_a", 64'(ready_out), 64'd1);
    @(posedge clk_in);
    sb_q.push_back(xa);
    #1 drive(1'b1, 8'h82, 23'h000010, 3'b011, 2'b11);
    @(negedge clk_in);
    chk("bp_ready_b", 64'(ready_out), 64'd1);
    @(posedge clk_in);
    sb_q.push_back(xb);
    #1 drive(1'b0, 8'h83, 23'h7FFFFF, 3'b001, 2'b10);
    @(negedge clk_in);
    chk("bp_ready_c", 64'(ready_out), 64'd0);
    chk("bp_valid_out", 64'(valid_out), 64'd1);
    held = floating_out;
    chk("bp_head_is_a", 64'(held), 64'(xa[31:0]));
    repeat (3) @(negedge clk_in);
    chk("bp_hold_word", 64'(floating_out), 64'(held));
    chk("bp_hold_ready", 64'(ready_out), 64'd0);
    @(posedge clk_in);
    #1 ready_in = 1'b1;
    @(negedge clk_in);
    chk("bp_release_ready", 64'(ready_out), 64'd1);
    @(posedge clk_in);
    sb_q.push_back(xc);
    #1 valid_in = 1'b0;
    drain();

    // Reset with both stages full
    ready_in = 1'b0;
    send(1'b0, 8'h90, 23'h000003, 3'b111, 2'b00, model(1'b0, 8'h90, 23'h000003, 3'b111, 2'b00));
    send(1'b1, 8'h91, 23'h000005, 3'b101, 2'b10, model(1'b1, 8'h91, 23'h000005, 3'b101, 2'b10));
    @(negedge clk_in);
    chk("pre_rst_valid", 64'(valid_out), 64'd1);
    #1 rst_in = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_word",  64'(floating_out), 64'd0);
    chk("mid_rst_flags", 64'({overflow_out, inexact_out}), 64'd0);
    sb_q.delete();
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    ready_in = 1'b1;
    send(1'b1, 8'h7F, 23'h000000, 3'b001, 2'b11, {2'b01, 32'hBF800001});
    @(negedge clk_in);
    chk("post_rst_lat1", 64'(valid_out), 64'd0);
    @(negedge clk_in);
    chk("post_rst_lat2", 64'(valid_out), 64'd1);
    @(posedge clk_in); #1;
    drain();

    // Random operands under random back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic        rs;
          logic [7:0]  re;
          logic [22:0] rf;
          logic [2:0]  rg;
          logic [1:0]  rm;
          rs = 1'($urandom);
          case ($urandom_range(0, 4))
            0: re = 8'hFE;
            1: re = 8'hFF;
            2: re = 8'h00;
            default: re = 8'($urandom);
          endcase
          rf = ($urandom_range(0, 2) == 0) ? 23'h7FFFFF : 23'($urandom);
          rg = 3'($urandom);
          rm = 2'($urandom);
          send(rs, re, rf, rg, rm, model(rs, re, rf, rg, rm));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_in);
          #1 ready_in = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ready_in = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
